// File: rtl/cnu_iter_ctrl_fsm.sv
// Iteration-control FSM for one CNU decode: initial load, per-iteration LUT
// read, wait for the handshake's toggle-style write, then advance the
// iteration phase. Every output is a register fed from the state register,
// so no input reaches an output combinationally.
module cnu_iter_ctrl_fsm #(
  parameter int INIT_CYCLES = 2,
  parameter int RD_CYCLES   = 4,
  parameter int MAX_ITER    = 10,
  parameter int ITER_W      = 4,
  parameter int WR_TIMEOUT  = 16
) (
  input  logic              read_clk,
  input  logic              rstn,
  input  logic              start_i,
  input  logic              early_term_i,
  input  logic              cnu_wr_i,
  output logic              cnu_init_load_en_o,
  output logic              cnu_rd_finish_o,
  output logic              iter_update_o,
  output logic [ITER_W-1:0] iter_cnt_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT_LOAD,
    S_READ,
    S_WAIT_WR,
    S_ITER_UP,
    S_DONE
  } state_t;

  localparam logic [7:0]      INIT_LAST = 8'(INIT_CYCLES - 1);
  localparam logic [7:0]      RD_LAST   = 8'(RD_CYCLES - 1);
  localparam logic [7:0]      TO_LAST   = 8'(WR_TIMEOUT - 1);
  localparam logic [ITER_W:0] MAX_EXT   = (ITER_W + 1)'(MAX_ITER);
  localparam logic [ITER_W:0] ONE_EXT   = (ITER_W + 1)'(1);

  state_t            state;
  state_t            state_next;
  logic [7:0]        cnt;
  logic              cnt_clr;
  logic              wr_ref;
  logic              early;
  logic [ITER_W-1:0] iter_cnt;
  logic [ITER_W:0]   iter_inc;
  logic              accept;
  logic              timeout;
  logic              start_ok;
  logic              last_iter;

  assign iter_cnt_o = iter_cnt;

  // Next-state decode; the phase counter restarts whenever a phase is left.
  // A start is only honoured once busy_o has dropped, so a request during
  // DONE or during the done_o cycle is dropped.
  always_comb begin
    state_next = state;
    cnt_clr    = 1'b0;
    timeout    = 1'b0;
    accept     = (cnu_wr_i != wr_ref);
    start_ok   = start_i && !busy_o;
    iter_inc   = {1'b0, iter_cnt} + ONE_EXT;
    last_iter  = early || (iter_inc == MAX_EXT);
    case (state)
      S_IDLE: begin
        if (start_ok) begin
          state_next = S_INIT_LOAD;
          cnt_clr    = 1'b1;
        end
      end
      S_INIT_LOAD: begin
        if (cnt == INIT_LAST) begin
          state_next = S_READ;
          cnt_clr    = 1'b1;
        end
      end
      S_READ: begin
        if (cnt == RD_LAST) begin
          state_next = S_WAIT_WR;
          cnt_clr    = 1'b1;
        end
      end
      S_WAIT_WR: begin
        if (accept) begin
          state_next = S_ITER_UP;
          cnt_clr    = 1'b1;
        end else if (cnt == TO_LAST) begin
          state_next = S_DONE;
          cnt_clr    = 1'b1;
          timeout    = 1'b1;
        end
      end
      S_ITER_UP: begin
        state_next = last_iter ? S_DONE : S_READ;
        cnt_clr    = 1'b1;
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge read_clk or negedge rstn) begin
    if (!rstn) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Phase counter, write reference, early-term capture, iteration count,
  // phase bit and sticky error; the phase bit survives between decodes.
  always_ff @(posedge read_clk or negedge rstn) begin
    if (!rstn) begin
      cnt           <= '0;
      wr_ref        <= 1'b0;
      early         <= 1'b0;
      iter_cnt      <= '0;
      iter_update_o <= 1'b0;
      err_o         <= 1'b0;
    end else begin
      if (cnt_clr) begin
        cnt <= '0;
      end else if (state == S_INIT_LOAD || state == S_READ || state == S_WAIT_WR) begin
        cnt <= cnt + 8'd1;
      end
      if (state == S_READ && state_next == S_WAIT_WR) begin
        wr_ref <= cnu_wr_i;
      end
      if (state == S_WAIT_WR && accept) begin
        early <= early_term_i;
      end
      if (state == S_IDLE && start_ok) begin
        iter_cnt <= '0;
        err_o    <= 1'b0;
      end
      if (timeout) begin
        err_o <= 1'b1;
      end
      if (state == S_ITER_UP) begin
        iter_update_o <= ~iter_update_o;
        if ({1'b0, iter_cnt} != MAX_EXT) begin
          iter_cnt <= iter_cnt + ITER_W'(1);
        end
      end
    end
  end

  // Registered Moore outputs decoded from the current state.
  always_ff @(posedge read_clk or negedge rstn) begin
    if (!rstn) begin
      cnu_init_load_en_o <= 1'b0;
      cnu_rd_finish_o    <= 1'b0;
      busy_o             <= 1'b0;
      done_o             <= 1'b0;
    end else begin
      cnu_init_load_en_o <= (state == S_INIT_LOAD);
      cnu_rd_finish_o    <= (state == S_WAIT_WR);
      busy_o             <= (state != S_IDLE);
      done_o             <= (state == S_DONE);
    end
  end

endmodule
